// File: rtl/mem_line_responder_if.sv
// Request/response bundle for the line responder.
// Line data travels on a separate inout port.
interface mem_line_responder_if;
  logic        readM;
  logic        writeM;
  logic [15:0] addressM;
  logic        readyM;
  logic        busyM;
  logic        errM;
  logic [15:0] read_cnt;
  logic [15:0] write_cnt;

  modport master (
    output readM, writeM, addressM,
    input  readyM, busyM, errM,
    input  read_cnt, write_cnt
  );

  modport slave (
    input  readM, writeM, addressM,
    output readyM, busyM, errM,
    output read_cnt, write_cnt
  );
endinterface

// File: rtl/mem_line_responder.sv
// Fixed-latency 4-word line memory with a level-held
// read/write handshake and saturating op counters.
module mem_line_responder #(
  parameter int LATENCY       = 4,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_line_responder_if.slave  bus,
  inout  wire  [63:0]          dataM
);

  localparam int LW = MEM_ADDR_BITS - 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    RELEASE
  } state_t;

  state_t      state;
  logic        isWrite;
  logic [LW-1:0] lineAddr;
  logic [63:0] wrLine;
  logic [63:0] rdLine;
  logic [3:0]  cnt;
  logic        readyQ;
  logic        busyQ;
  logic        errQ;
  logic [15:0] rdCnt;
  logic [15:0] wrCnt;
  logic [63:0] mem [2**LW];

  logic reqRd;
  logic reqWr;
  logic commit;
  logic unusedAddr;

  assign reqRd  = bus.readM;
  assign reqWr  = bus.writeM;
  assign commit = (state == BUSY) && (cnt == 4'd1);

  // Upper bits alias, low bits select a word in the line.
  assign unusedAddr = ^{bus.addressM[15:MEM_ADDR_BITS],
                        bus.addressM[1:0]};

  assign dataM = (state == DONE && !isWrite) ? rdLine : 64'bz;

  assign bus.readyM    = readyQ;
  assign bus.busyM     = busyQ;
  assign bus.errM      = errQ;
  assign bus.read_cnt  = rdCnt;
  assign bus.write_cnt = wrCnt;

  // Array is not reset; an aborted write never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && isWrite)
      mem[lineAddr] <= wrLine;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      isWrite  <= 1'b0;
      lineAddr <= '0;
      wrLine   <= '0;
      rdLine   <= '0;
      cnt      <= '0;
      readyQ   <= 1'b0;
      busyQ    <= 1'b0;
      errQ     <= 1'b0;
      rdCnt    <= '0;
      wrCnt    <= '0;
    end else begin
      readyQ <= 1'b0;
      errQ   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (reqRd ^ reqWr) begin
            isWrite  <= reqWr;
            lineAddr <= bus.addressM[MEM_ADDR_BITS-1:2];
            if (reqWr)
              wrLine <= dataM;
            cnt   <= 4'(LATENCY);
            busyQ <= 1'b1;
            state <= BUSY;
          end else if (reqRd && reqWr) begin
            errQ  <= 1'b1;
            state <= RELEASE;
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state  <= DONE;
            readyQ <= 1'b1;
            rdLine <= mem[lineAddr];
            if (isWrite) begin
              if (wrCnt != 16'hFFFF)
                wrCnt <= wrCnt + 16'd1;
            end else begin
              if (rdCnt != 16'hFFFF)
                rdCnt <= rdCnt + 16'd1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          busyQ <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (!reqRd && !reqWr)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: latency 4
// instance plus a latency 1 instance.
module tb_mem_line_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_line_responder_if ifA ();
  mem_line_responder_if ifB ();

  logic        drvA = 1'b0;
  logic        drvB = 1'b0;
  logic [63:0] tbDataA = '0;
  logic [63:0] tbDataB = '0;
  wire  [63:0] dataA;
  wire  [63:0] dataB;

  assign dataA = drvA ? tbDataA : 64'bz;
  assign dataB = drvB ? tbDataB : 64'bz;

  mem_line_responder #(.LATENCY(4), .MEM_ADDR_BITS(10)) dutA (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifA.slave),
    .dataM   (dataA)
  );

  mem_line_responder #(.LATENCY(1), .MEM_ADDR_BITS(10)) dutB (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifB.slave),
    .dataM   (dataB)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int sel, input logic rd,
                        input logic wr, input logic [15:0] a);
    if (sel == 0) begin
      ifA.readM = rd; ifA.writeM = wr; ifA.addressM = a;
    end else begin
      ifB.readM = rd; ifB.writeM = wr; ifB.addressM = a;
    end
  endtask

  task automatic setDrv(input int sel, input logic en,
                        input logic [63:0] d);
    if (sel == 0) begin
      drvA = en; tbDataA = d;
    end else begin
      drvB = en; tbDataB = d;
    end
  endtask

  function automatic logic getReady(input int sel);
    return (sel == 0) ? ifA.readyM : ifB.readyM;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 0) ? ifA.busyM : ifB.busyM;
  endfunction

  function automatic logic [63:0] getData(input int sel);
    return (sel == 0) ? dataA : dataB;
  endfunction

  // One full transaction; address is scrambled after acceptance.
  task automatic doOp(input int sel, input logic isWr,
                      input logic [15:0] a,
                      input logic [63:0] d,
                      output int lat,
                      output logic [63:0] q,
                      output logic bz);
    @(negedge clk);
    setReq(sel, !isWr, isWr, a);
    setDrv(sel, isWr, d);
    @(posedge clk); #1;
    setDrv(sel, 1'b0, '0);
    setReq(sel, !isWr, isWr, 16'hFFFC);
    lat = 0;
    q   = '0;
    bz  = 1'b0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (getReady(sel)) begin
        q  = getData(sel);
        bz = getBusy(sel);
        break;
      end
    end
    @(negedge clk);
    setReq(sel, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
  endtask

  int          lat;
  logic [63:0] q;
  logic        bz;
  int          nReady;
  int          nErr;

  localparam logic [63:0] D1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D3 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D5 = 64'hFEDC_BA98_7654_3210;

  initial begin
    setReq(0, 1'b0, 1'b0, 16'h0000);
    setReq(1, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst readyM", 64'(ifA.readyM), 64'd0);
    chk("rst busyM", 64'(ifA.busyM), 64'd0);
    chk("rst errM", 64'(ifA.errM), 64'd0);
    chk("rst read_cnt", 64'(ifA.read_cnt), 64'd0);
    chk("rst write_cnt", 64'(ifA.write_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    doOp(0, 1'b1, 16'h0014, D1, lat, q, bz);
    chk("wr lat", 64'(lat), 64'd4);
    chk("wr busy@done", 64'(bz), 64'd1);
    chk("wr cnt", 64'(ifA.write_cnt), 64'd1);

    doOp(0, 1'b0, 16'h0017, '0, lat, q, bz);
    chk("rd lat", 64'(lat), 64'd4);
    chk("rd data", q, D1);
    chk("rd cnt", 64'(ifA.read_cnt), 64'd1);
    chk("wr cnt2", 64'(ifA.write_cnt), 64'd1);

    // Held read: one completion, then parked in RELEASE.
    @(negedge clk);
    setReq(0, 1'b1, 1'b0, 16'h0014);
    nReady = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ifA.readyM) nReady++;
    end
    chk("hold ready", 64'(nReady), 64'd1);
    chk("hold busy", 64'(ifA.busyM), 64'd0);
    chk("hold rdcnt", 64'(ifA.read_cnt), 64'd2);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);

    // Conflicting request.
    @(negedge clk);
    setReq(0, 1'b1, 1'b1, 16'h0014);
    setDrv(0, 1'b1, D3);
    nReady = 0;
    nErr   = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ifA.readyM) nReady++;
      if (ifA.errM) nErr++;
    end
    chk("err pulses", 64'(nErr), 64'd1);
    chk("err ready", 64'(nReady), 64'd0);
    chk("err rdcnt", 64'(ifA.read_cnt), 64'd2);
    chk("err wrcnt", 64'(ifA.write_cnt), 64'd1);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 16'h0000);
    setDrv(0, 1'b0, '0);
    repeat (2) @(posedge clk);
    doOp(0, 1'b0, 16'h0014, '0, lat, q, bz);
    chk("err array", q, D1);

    // Reset in the middle of a write.
    doOp(0, 1'b1, 16'h0020, D2, lat, q, bz);
    chk("pre wrcnt", 64'(ifA.write_cnt), 64'd2);
    @(negedge clk);
    setReq(0, 1'b0, 1'b1, 16'h0020);
    setDrv(0, 1'b1, D3);
    @(posedge clk); #1;
    setDrv(0, 1'b0, '0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort busy", 64'(ifA.busyM), 64'd0);
    nReady = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ifA.readyM) nReady++;
    end
    chk("abort ready", 64'(nReady), 64'd0);
    chk("abort wrcnt", 64'(ifA.write_cnt), 64'd0);
    chk("abort rdcnt", 64'(ifA.read_cnt), 64'd0);
    @(negedge clk);
    setReq(0, 1'b0, 1'b0, 16'h0000);
    reset_n = 1'b1;
    doOp(0, 1'b0, 16'h0020, '0, lat, q, bz);
    chk("abort data", q, D2);
    chk("abort rd lat", 64'(lat), 64'd4);

    // Upper address bits alias.
    doOp(0, 1'b1, 16'h0404, D4, lat, q, bz);
    doOp(0, 1'b0, 16'h0004, '0, lat, q, bz);
    chk("alias data", q, D4);
    doOp(0, 1'b0, 16'h0014, '0, lat, q, bz);
    chk("alias other", q, D1);

    doOp(1, 1'b1, 16'h0008, D5, lat, q, bz);
    chk("lat1 wr lat", 64'(lat), 64'd1);
    doOp(1, 1'b0, 16'h0009, '0, lat, q, bz);
    chk("lat1 rd lat", 64'(lat), 64'd1);
    chk("lat1 rd data", q, D5);
    chk("lat1 rdcnt", 64'(ifB.read_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
